sdram_arbit: RTL and testbench

- Top-level SDRAM sequencer. Holds the master state machine that the init, auto-refresh, write and read sub-blocks decode through the `state` bus.
- Grants the single SDRAM command/address bus to exactly one sub-block at a time, with fixed priority refresh > write > read.
- Muxes the granted sub-block's cmd/addr/bank onto the SDRAM pins.
- Watchdog returns the FSM to arbitration if a granted sub-block never signals end.

---
 rtl/sdram_arbit.sv | 149 ++++++++++++++
 tb/tb_sdram_arbit.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbit.sv
// SDRAM master sequencer: owns the state bus decoded by the init/refresh/write/read
// sub-blocks, grants the command bus with priority refresh > write > read, and muxes pins.
module sdram_arbit #(
  parameter int         TIMEOUT = 64,
  parameter logic [3:0] NOP     = 4'b0111
) (
  input  logic        sclk,
  input  logic        s_rst_n,
  input  logic        flag_init_end,
  input  logic [3:0]  init_cmd,
  input  logic [11:0] init_addr,
  input  logic        ref_req,
  input  logic        flag_ref_end,
  input  logic [3:0]  ref_cmd,
  input  logic [11:0] ref_addr,
  input  logic        wr_req,
  input  logic        flag_wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [11:0] wr_addr,
  input  logic [1:0]  wr_bank,
  input  logic        rd_req,
  input  logic        flag_rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [11:0] rd_addr,
  input  logic [1:0]  rd_bank,
  output logic [4:0]  state,
  output logic        ref_en,
  output logic        wr_en,
  output logic        rd_en,
  output logic [3:0]  sdram_cmd,
  output logic [11:0] sdram_addr,
  output logic [1:0]  sdram_bank,
  output logic        timeout_err
);

  typedef enum logic [4:0] {
    S_AREF  = 5'b00000,
    S_INIT  = 5'b00001,
    S_ARBIT = 5'b00010,
    S_WRITE = 5'b00100,
    S_READ  = 5'b01000
  } state_t;

  localparam logic [7:0] T_LAST = 8'(TIMEOUT - 1);

  state_t     cur_state;
  logic [7:0] timer;
  logic       end_flag;

  assign state = cur_state;

  // Only the end flag of the block that owns the bus counts; the others are ignored.
  always_comb begin
    end_flag = 1'b0;
    case (cur_state)
      S_AREF:  end_flag = flag_ref_end;
      S_WRITE: end_flag = flag_wr_end;
      S_READ:  end_flag = flag_rd_end;
      default: end_flag = 1'b0;
    endcase
  end

  // Handshake: a sub-block holds *_req high until it sees its *_en pulse; *_en is high
  // only in the first cycle `state` shows the granted service state, and the block
  // releases the bus with a one-cycle flag_*_end pulse while it still owns the state.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      cur_state   <= S_INIT;
      ref_en      <= 1'b0;
      wr_en       <= 1'b0;
      rd_en       <= 1'b0;
      timeout_err <= 1'b0;
      timer       <= 8'd0;
    end else begin
      ref_en      <= 1'b0;
      wr_en       <= 1'b0;
      rd_en       <= 1'b0;
      timeout_err <= 1'b0;
      case (cur_state)
        S_INIT: begin
          timer <= 8'd0;
          if (flag_init_end) cur_state <= S_ARBIT;
        end
        S_ARBIT: begin
          timer <= 8'd0;
          if (ref_req) begin
            cur_state <= S_AREF;
            ref_en    <= 1'b1;
          end else if (wr_req) begin
            cur_state <= S_WRITE;
            wr_en     <= 1'b1;
          end else if (rd_req) begin
            cur_state <= S_READ;
            rd_en     <= 1'b1;
          end
        end
        S_AREF, S_WRITE, S_READ: begin
          // Every exit goes through ARBIT so a pending refresh is always re-arbitrated.
          if (end_flag) begin
            cur_state <= S_ARBIT;
            timer     <= 8'd0;
          end else if (timer == T_LAST) begin
            cur_state   <= S_ARBIT;
            timeout_err <= 1'b1;
            timer       <= 8'd0;
          end else if (timer != 8'hff) begin
            timer <= timer + 8'd1;
          end
        end
        default: begin
          cur_state <= S_ARBIT;
          timer     <= 8'd0;
        end
      endcase
    end
  end

  always_comb begin
    sdram_cmd  = NOP;
    sdram_addr = 12'd0;
    sdram_bank = 2'd0;
    case (cur_state)
      S_INIT: begin
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
      end
      S_AREF: begin
        sdram_cmd  = ref_cmd;
        sdram_addr = ref_addr;
      end
      S_WRITE: begin
        sdram_cmd  = wr_cmd;
        sdram_addr = wr_addr;
        sdram_bank = wr_bank;
      end
      S_READ: begin
        sdram_cmd  = rd_cmd;
        sdram_addr = rd_addr;
        sdram_bank = rd_bank;
      end
      default: begin
        sdram_cmd  = NOP;
        sdram_addr = 12'd0;
        sdram_bank = 2'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_sdram_arbit.sv
// Bench for sdram_arbit: directed scenarios with literal expectations, then random
// request/end-flag traffic checked every cycle against a bus-ownership model.
module tb_sdram_arbit;

  localparam int TO = 64;

  logic        sclk = 1'b0;
  logic        s_rst_n;
  logic        flag_init_end;
  logic [3:0]  init_cmd, ref_cmd, wr_cmd, rd_cmd;
  logic [11:0] init_addr, ref_addr, wr_addr, rd_addr;
  logic [1:0]  wr_bank, rd_bank;
  logic        ref_req, wr_req, rd_req;
  logic        flag_ref_end, flag_wr_end, flag_rd_end;
  logic [4:0]  state;
  logic        ref_en, wr_en, rd_en, timeout_err;
  logic [3:0]  sdram_cmd;
  logic [11:0] sdram_addr;
  logic [1:0]  sdram_bank;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  // clock / reset
  always #5 sclk = ~sclk;

  sdram_arbit #(.TIMEOUT(TO), .NOP(4'b0111)) dut (
    .sclk(sclk), .s_rst_n(s_rst_n), .flag_init_end(flag_init_end),
    .init_cmd(init_cmd), .init_addr(init_addr),
    .ref_req(ref_req), .flag_ref_end(flag_ref_end), .ref_cmd(ref_cmd), .ref_addr(ref_addr),
    .wr_req(wr_req), .flag_wr_end(flag_wr_end), .wr_cmd(wr_cmd), .wr_addr(wr_addr),
    .wr_bank(wr_bank),
    .rd_req(rd_req), .flag_rd_end(flag_rd_end), .rd_cmd(rd_cmd), .rd_addr(rd_addr),
    .rd_bank(rd_bank),
    .state(state), .ref_en(ref_en), .wr_en(wr_en), .rd_en(rd_en),
    .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_bank(sdram_bank),
    .timeout_err(timeout_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus-ownership model: phase 0 = init, 1 = nobody owns the bus, 2 = owned by m_who
  // (0 refresh, 1 write, 2 read) for m_cnt cycles so far.
  int m_phase, m_who, m_cnt;
  bit m_grant, m_err;

  task automatic model_step();
    logic [2:0] reqs;
    logic [2:0] ends;
    reqs = {rd_req, wr_req, ref_req};
    ends = {flag_rd_end, flag_wr_end, flag_ref_end};
    m_grant = 1'b0;
    m_err   = 1'b0;
    if (m_phase == 0) begin
      if (flag_init_end) m_phase = 1;
    end else if (m_phase == 1) begin
      for (int i = 0; i < 3; i++)
        if (reqs[i] && m_phase == 1) begin
          m_phase = 2; m_who = i; m_cnt = 1; m_grant = 1'b1;
        end
    end else begin
      if (ends[m_who]) m_phase = 1;
      else if (m_cnt == TO) begin m_phase = 1; m_err = 1'b1; end
      else m_cnt++;
    end
  endtask

  always @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      m_phase = 0; m_who = 0; m_cnt = 0; m_grant = 1'b0; m_err = 1'b0;
    end else begin
      model_step();
    end
  end

  function automatic logic [4:0] exp_state();
    if (m_phase == 0) return 5'b00001;
    if (m_phase == 1) return 5'b00010;
    case (m_who)
      0:       return 5'b00000;
      1:       return 5'b00100;
      default: return 5'b01000;
    endcase
  endfunction

  function automatic logic [17:0] exp_bus();
    if (m_phase == 0) return {init_cmd, init_addr, 2'd0};
    if (m_phase == 1) return {4'b0111, 12'd0, 2'd0};
    case (m_who)
      0:       return {ref_cmd, ref_addr, 2'd0};
      1:       return {wr_cmd, wr_addr, wr_bank};
      default: return {rd_cmd, rd_addr, rd_bank};
    endcase
  endfunction

  // scoreboard compare, away from the active edge
  always @(negedge sclk) begin
    if (check_en) begin
      chk("state", 32'(state), 32'(exp_state()));
      chk("ref_en", 32'(ref_en), 32'(m_grant && m_phase == 2 && m_who == 0));
      chk("wr_en", 32'(wr_en), 32'(m_grant && m_phase == 2 && m_who == 1));
      chk("rd_en", 32'(rd_en), 32'(m_grant && m_phase == 2 && m_who == 2));
      chk("timeout_err", 32'(timeout_err), 32'(m_err));
      chk("sdram_bus", 32'({sdram_cmd, sdram_addr, sdram_bank}), 32'(exp_bus()));
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic clear_ends();
    flag_ref_end = 1'b0; flag_wr_end = 1'b0; flag_rd_end = 1'b0;
  endtask

  task automatic set_end(input int k);
    case (k)
      0:       flag_ref_end = 1'b1;
      1:       flag_wr_end  = 1'b1;
      default: flag_rd_end  = 1'b1;
    endcase
  endtask

  task automatic clear_req(input int k);
    case (k)
      0:       ref_req = 1'b0;
      1:       wr_req  = 1'b0;
      default: rd_req  = 1'b0;
    endcase
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  initial begin
    int order, ngr, bad, n, plan, own, k;
    logic [4:0] prev;

    s_rst_n = 1'b1; flag_init_end = 1'b0;
    init_cmd = 4'b0010; init_addr = 12'h400;
    ref_cmd = 4'b0001; ref_addr = 12'h0aa;
    wr_cmd = 4'b0100; wr_addr = 12'h3c3; wr_bank = 2'd1;
    rd_cmd = 4'b0101; rd_addr = 12'h123; rd_bank = 2'd2;
    ref_req = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    clear_ends();

    // reset and init
    #1 s_rst_n = 1'b0;
    #1;
    check_en = 1'b1;
    chk("reset_state", 32'(state), 32'(5'b00001));
    chk("reset_en", 32'({ref_en, wr_en, rd_en, timeout_err}), 32'(4'b0000));
    repeat (3) tick();
    s_rst_n = 1'b1;
    for (int c = 1; c < 10; c++) tick();
    chk("init_hold", 32'(state), 32'(5'b00001));
    chk("init_cmd_mux", 32'(sdram_cmd), 32'(4'b0010));
    flag_init_end = 1'b1;
    tick();
    chk("init_to_arbit", 32'(state), 32'(5'b00010));
    chk("arbit_nop", 32'({sdram_cmd, sdram_addr}), 32'({4'b0111, 12'd0}));

    // single read
    rd_req = 1'b1;
    tick();
    chk("rd_state", 32'(state), 32'(5'b01000));
    chk("rd_en_pulse", 32'(rd_en), 32'(1'b1));
    chk("rd_mux", 32'({sdram_cmd, sdram_addr, sdram_bank}), 32'({4'b0101, 12'h123, 2'd2}));
    rd_req = 1'b0;
    tick();
    chk("rd_en_once", 32'(rd_en), 32'(1'b0));
    repeat (11) tick();
    flag_rd_end = 1'b1;
    tick();
    clear_ends();
    chk("rd_done", 32'(state), 32'(5'b00010));

    // simultaneous requests
    ref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    order = 0; ngr = 0; bad = 0; prev = state;
    for (int g = 0; g < 80 && (ngr < 3 || state != 5'b00010); g++) begin
      tick();
      clear_ends();
      if (prev != 5'b00010 && state != 5'b00010 && state != prev) bad++;
      prev = state;
      if (ref_en) begin order = (order << 2) | 0; ngr++; ref_req = 1'b0; end
      if (wr_en)  begin order = (order << 2) | 1; ngr++; wr_req  = 1'b0; end
      if (rd_en)  begin order = (order << 2) | 2; ngr++; rd_req  = 1'b0; end
      if (m_phase == 2 && m_cnt == 3) set_end(m_who);
    end
    tick();
    clear_ends();
    chk("grant_count", 32'(ngr), 32'd3);
    chk("grant_order", 32'(order), 32'(6'b000110));
    chk("direct_svc_hops", 32'(bad), 32'd0);

    // refresh arrives during write; foreign end flags ignored
    wr_req = 1'b1;
    tick();
    chk("wr_state", 32'(state), 32'(5'b00100));
    chk("wr_mux", 32'({sdram_cmd, sdram_addr, sdram_bank}), 32'({4'b0100, 12'h3c3, 2'd1}));
    wr_req = 1'b0; ref_req = 1'b1;
    tick();
    flag_rd_end = 1'b1;
    tick();
    clear_ends();
    tick();
    flag_rd_end = 1'b1; flag_ref_end = 1'b1;
    tick();
    clear_ends();
    chk("wr_ignores_foreign", 32'(state), 32'(5'b00100));
    flag_wr_end = 1'b1;
    tick();
    clear_ends();
    chk("wr_to_arbit", 32'(state), 32'(5'b00010));
    tick();
    chk("ref_after_wr", 32'({state, ref_en}), 32'({5'b00000, 1'b1}));
    ref_req = 1'b0;
    tick();
    flag_ref_end = 1'b1;
    tick();
    clear_ends();
    chk("ref_done", 32'(state), 32'(5'b00010));

    // watchdog
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    n = (state == 5'b01000) ? 1 : 0;
    for (int g = 0; g < 100 && state == 5'b01000; g++) begin
      tick();
      if (state == 5'b01000) n++;
    end
    chk("read_cycles_before_timeout", 32'(n), 32'd64);
    chk("timeout_pulse", 32'({state, timeout_err}), 32'({5'b00010, 1'b1}));
    tick();
    chk("timeout_pulse_once", 32'(timeout_err), 32'(1'b0));
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    repeat (63) tick();
    chk("tie_still_read", 32'(state), 32'(5'b01000));
    flag_rd_end = 1'b1;
    tick();
    clear_ends();
    chk("tie_end_wins", 32'({state, timeout_err}), 32'({5'b00010, 1'b0}));

    // asynchronous reset during write
    wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
    chk("wr_en_before_reset", 32'(wr_en), 32'(1'b1));
    #2 s_rst_n = 1'b0;
    #1;
    chk("async_reset_state", 32'(state), 32'(5'b00001));
    chk("async_reset_outs", 32'({ref_en, wr_en, rd_en, timeout_err}), 32'(4'b0000));
    tick();
    s_rst_n = 1'b1;
    tick();
    chk("post_reset_arbit", 32'(state), 32'(5'b00010));

    // randomized traffic
    plan = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      init_cmd = 4'($urandom); init_addr = 12'($urandom);
      ref_cmd = 4'($urandom); ref_addr = 12'($urandom);
      wr_cmd = 4'($urandom); wr_addr = 12'($urandom); wr_bank = 2'($urandom);
      rd_cmd = 4'($urandom); rd_addr = 12'($urandom); rd_bank = 2'($urandom);
      clear_ends();
      if (!ref_req && $urandom_range(0, 11) == 0) ref_req = 1'b1;
      if (!wr_req && $urandom_range(0, 7) == 0) wr_req = 1'b1;
      if (!rd_req && $urandom_range(0, 7) == 0) rd_req = 1'b1;
      if (m_phase == 2 && m_grant) begin
        clear_req(m_who);
        k = $urandom_range(0, 9);
        plan = (k == 0) ? 200 : (k == 1) ? TO : (k == 2) ? TO - 1 : $urandom_range(1, 20);
      end
      own = (m_phase == 2) ? m_who : -1;
      if (m_phase == 2 && m_cnt == plan) set_end(m_who);
      if ($urandom_range(0, 7) == 0) begin
        k = $urandom_range(0, 2);
        if (k != own) set_end(k);
      end
    end
    tick();
    check_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
